// File: rtl/sprite_pixel_sink.sv
// ============================================================================
// sprite_pixel_sink : sequences one sprite draw, aligns x/y with ROM colour,
//                     clips to screen, drops key colour, strobes VGA writes.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sprite_pixel_sink #(
    parameter int unsigned ROM_LATENCY = 1,
    parameter int unsigned SCREEN_W    = 320,
    parameter int unsigned SCREEN_H    = 240,
    parameter bit          KEY_EN      = 1'b1,
    parameter logic [2:0]  KEY_COLOUR  = 3'b111,
    parameter int unsigned MAX_CYCLES  = 65535
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [8:0]  src_x_i,
    input  logic [7:0]  src_y_i,
    input  logic [2:0]  src_colour_i,
    input  logic        src_done_i,
    output logic        src_enable_o,
    output logic        src_reset_n_o,
    output logic [8:0]  vga_x_o,
    output logic [7:0]  vga_y_o,
    output logic [2:0]  vga_colour_o,
    output logic        vga_plot_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [16:0] plot_count_o
);

    localparam int unsigned DEPTH   = ROM_LATENCY + 1;
    localparam int unsigned WD_W    = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYCLES - 1);
    localparam logic [2:0]      FL_LAST = 3'(ROM_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [2:0]        fl_q, fl_d;
    logic              accept, timeout_set;

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        fl_d        = fl_q;
        accept      = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wd_d    = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                wd_d = wd_q + 1'b1;
                // src_done wins over the watchdog on the same cycle
                if (src_done_i) begin
                    fl_d    = '0;
                    state_d = S_FLUSH;
                end else if (wd_q == WD_LAST) begin
                    fl_d        = '0;
                    timeout_set = 1'b1;
                    state_d     = S_FLUSH;
                end
            end
            S_FLUSH: begin
                fl_d = fl_q + 3'd1;
                if (fl_q == FL_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stage DEPTH-1 of x/y lines up with colour_q, which trails the ROM by one register.
    logic [DEPTH-1:0] pv_q;
    logic [8:0]       px_q [DEPTH];
    logic [7:0]       py_q [DEPTH];
    logic [2:0]       colour_q;
    logic             valid_in, on_screen, keyed, plot_d;

    assign valid_in  = (state_q == S_STREAM);
    assign on_screen = ({23'd0, px_q[DEPTH-1]} < SCREEN_W) && ({24'd0, py_q[DEPTH-1]} < SCREEN_H);
    assign keyed     = KEY_EN && (colour_q == KEY_COLOUR);
    assign plot_d    = pv_q[DEPTH-1] && on_screen && !keyed;

    logic        src_enable_q, src_reset_n_q, vga_plot_q, busy_q, done_q, timeout_q;
    logic [8:0]  vga_x_q;
    logic [7:0]  vga_y_q;
    logic [2:0]  vga_colour_q;
    logic [16:0] plot_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            wd_q          <= '0;
            fl_q          <= '0;
            pv_q          <= '0;
            colour_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
            src_enable_q  <= 1'b0;
            src_reset_n_q <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_plot_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            plot_count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            fl_q     <= fl_d;
            pv_q     <= {pv_q[DEPTH-2:0], valid_in};
            colour_q <= src_colour_i;
            px_q[0]  <= src_x_i;
            py_q[0]  <= src_y_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
            src_enable_q  <= (state_d == S_STREAM);
            src_reset_n_q <= (state_d == S_STREAM) || (state_d == S_FLUSH) || (state_d == S_DONE);
            busy_q        <= (state_d == S_CLEAR) || (state_d == S_STREAM) || (state_d == S_FLUSH);
            done_q        <= (state_d == S_DONE);
            vga_x_q       <= px_q[DEPTH-1];
            vga_y_q       <= py_q[DEPTH-1];
            vga_colour_q  <= colour_q;
            vga_plot_q    <= plot_d;
            if (accept) begin
                timeout_q    <= 1'b0;
                plot_count_q <= '0;
            end else begin
                if (timeout_set) begin
                    timeout_q <= 1'b1;
                end
                if (plot_d && (plot_count_q != 17'h1FFFF)) begin
                    plot_count_q <= plot_count_q + 17'd1;
                end
            end
        end
    end

    assign src_enable_o  = src_enable_q;
    assign src_reset_n_o = src_reset_n_q;
    assign vga_x_o       = vga_x_q;
    assign vga_y_o       = vga_y_q;
    assign vga_colour_o  = vga_colour_q;
    assign vga_plot_o    = vga_plot_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign plot_count_o  = plot_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_pixel_sink.sv
// ============================================================================
// tb_sprite_pixel_sink : random sprite draws against a pixel-list model.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sprite_pixel_sink;

    localparam int L     = 1;
    localparam int MAXC  = 100;
    localparam bit KEYEN = 1'b1;
    localparam int SW    = 320;
    localparam int SH    = 240;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [8:0]  src_x = '0;
    logic [7:0]  src_y = '0;
    logic [2:0]  src_colour = '0;
    logic        src_done = 1'b0;
    logic        src_enable, src_reset_n, vga_plot, busy, done, timeout;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic [16:0] plot_count;

    sprite_pixel_sink #(
        .ROM_LATENCY(L), .SCREEN_W(SW), .SCREEN_H(SH),
        .KEY_EN(KEYEN), .KEY_COLOUR(3'b111), .MAX_CYCLES(MAXC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .src_x_i(src_x), .src_y_i(src_y), .src_colour_i(src_colour), .src_done_i(src_done),
        .src_enable_o(src_enable), .src_reset_n_o(src_reset_n),
        .vga_x_o(vga_x), .vga_y_o(vga_y), .vga_colour_o(vga_colour), .vga_plot_o(vga_plot),
        .busy_o(busy), .done_o(done), .timeout_o(timeout), .plot_count_o(plot_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", nm, edge_n, act, exp);
        end
    endtask

    // Sprite source: raster counter held at origin by src_reset_n, ROM colour L cycles late.
    int         sx0 = 0, sy0 = 0, sw = 1, stot = 1;
    bit         sden = 1'b1;
    logic [2:0] scol [0:511];

    initial begin
        int idx = 0;
        int hist [8];
        bit en_s, rn_s;
        for (int i = 0; i < 8; i++) hist[i] = 0;
        forever begin
            @(negedge clk);
            en_s = src_enable;
            rn_s = src_reset_n;
            @(posedge clk);
            #1;
            if (!rn_s) idx = 0;
            else if (en_s && idx < stot - 1) idx++;
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0]    = idx;
            src_x      = 9'(sx0 + idx % sw);
            src_y      = 8'(sy0 + idx / sw);
            src_done   = sden && (idx == stot - 1);
            src_colour = scol[hist[L]];
        end
    end

    // Model: per draw, the list of sampled pixels and their visibility; pixel k of a
    // draw accepted at edge s is sampled at s+2+k and appears at s+k+L+3.
    int         m_s = 0, m_n = 0;
    bit         m_act = 1'b0, m_to = 1'b0;
    bit         m_vis [0:511];
    logic [8:0] m_x [0:511];
    logic [7:0] m_y [0:511];
    logic [2:0] m_c [0:511];
    int         m_pre [0:512];
    int         prev_cnt = 0;
    bit         prev_to = 1'b0;
    int         first_rel = -1, done_cnt = 0;
    logic [8:0] first_x;
    logic [7:0] first_y;
    logic [2:0] first_c;

    initial begin
        forever begin
            @(negedge clk);
            begin
                int rel, k, kk, epc;
                bit eb, ed, ee, er, ep, et;
                rel = edge_n - m_s;
                if (!m_act || rel < 0) begin
                    {eb, ed, ee, er, ep} = '0;
                    et  = prev_to;
                    epc = prev_cnt;
                    k   = -1;
                end else begin
                    eb = (rel < m_n + L + 2);
                    ed = (rel == m_n + L + 2);
                    ee = (rel >= 1) && (rel < m_n + 1);
                    er = (rel >= 1) && (rel <= m_n + L + 2);
                    et = (rel >= m_n + 1) ? m_to : 1'b0;
                    k  = rel - L - 3;
                    ep = (k >= 0) && (k < m_n) && m_vis[(k >= 0 && k < 512) ? k : 0];
                    kk = rel - L - 2;
                    if (kk < 0) kk = 0;
                    if (kk > m_n) kk = m_n;
                    epc = m_pre[kk];
                end
                chk("busy", 32'(busy), 32'(eb));
                chk("done", 32'(done), 32'(ed));
                chk("src_enable", 32'(src_enable), 32'(ee));
                chk("src_reset_n", 32'(src_reset_n), 32'(er));
                chk("timeout", 32'(timeout), 32'(et));
                chk("plot_count", 32'(plot_count), 32'(epc));
                chk("vga_plot", 32'(vga_plot), 32'(ep));
                if (ep) begin
                    chk("vga_x", 32'(vga_x), 32'(m_x[k]));
                    chk("vga_y", 32'(vga_y), 32'(m_y[k]));
                    chk("vga_colour", 32'(vga_colour), 32'(m_c[k]));
                end
                if (vga_plot && m_act && rel >= 0 && first_rel < 0) begin
                    first_rel = rel;
                    first_x   = vga_x;
                    first_y   = vga_y;
                    first_c   = vga_colour;
                end
                if (done) done_cnt++;
            end
        end
    end

    // cmode: -1 random, -2 raster colours k%8, >=0 constant colour
    task automatic begin_draw(input int x0, input int y0, input int w, input int h,
                              input bit den, input int cmode);
        @(posedge clk); #2;
        if (m_act) begin
            prev_cnt = m_pre[m_n];
            prev_to  = m_to;
        end
        sx0 = x0; sy0 = y0; sw = w; stot = w * h; sden = den;
        for (int k = 0; k < stot; k++)
            scol[k] = (cmode == -1) ? 3'($urandom) : (cmode == -2) ? 3'(k % 8) : 3'(cmode);
        m_to = !(den && stot <= MAXC);
        m_n  = m_to ? MAXC : stot;
        m_pre[0] = 0;
        for (int k = 0; k < m_n; k++) begin
            int id, xa, ya;
            id = (k < stot) ? k : stot - 1;
            xa = x0 + id % w;
            ya = y0 + id / w;
            m_x[k]   = 9'(xa);
            m_y[k]   = 8'(ya);
            m_c[k]   = scol[id];
            m_vis[k] = (xa < SW) && (ya < SH) && !(KEYEN && scol[id] == 3'b111);
            m_pre[k+1] = m_pre[k] + int'(m_vis[k]);
        end
        first_rel = -1;
        done_cnt  = 0;
        m_s   = edge_n + 1;
        m_act = 1'b1;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_end(input bit spur);
        if (spur) begin
            while (edge_n < m_s + 3) begin @(posedge clk); #2; end
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
            while (edge_n < m_s + m_n + L + 2) begin @(posedge clk); #2; end
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end
        while (edge_n < m_s + m_n + L + 4) begin @(posedge clk); #2; end
        chk("done_once", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 512; k++) scol[k] = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_plot_count", 32'(plot_count), 32'd0);
        chk("rst_src_reset_n", 32'(src_reset_n), 32'd0);
        rst_n = 1'b1;

        begin_draw(10, 20, 4, 2, 1'b1, -2);
        wait_end(1'b0);
        chk("t1_count", 32'(plot_count), 32'd7);
        chk("t1_first_latency", 32'(first_rel), 32'd4);
        chk("t1_first_x", 32'(first_x), 32'd10);
        chk("t1_first_y", 32'(first_y), 32'd20);
        chk("t1_first_colour", 32'(first_c), 32'd0);

        begin_draw(318, 50, 4, 3, 1'b1, 1);
        wait_end(1'b0);
        chk("t2_clip_count", 32'(plot_count), 32'd6);

        begin_draw(5, 5, 3, 3, 1'b1, 7);
        wait_end(1'b0);
        chk("t3_keyed_count", 32'(plot_count), 32'd0);

        begin_draw(0, 0, 20, 10, 1'b0, 2);
        wait_end(1'b0);
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_count", 32'(plot_count), 32'd100);
        begin_draw(30, 40, 2, 2, 1'b1, 3);
        @(negedge clk);
        chk("t4_timeout_cleared", 32'(timeout), 32'd0);
        wait_end(1'b0);
        chk("t4_next_count", 32'(plot_count), 32'd4);

        begin_draw(100, 100, 10, 10, 1'b1, -1);
        wait_end(1'b0);
        chk("exact_max_no_timeout", 32'(timeout), 32'd0);

        for (int i = 0; i < 12; i++) begin
            begin_draw(int'($urandom_range(280, 330)), int'($urandom_range(200, 245)),
                       int'($urandom_range(1, 12)), int'($urandom_range(1, 6)), 1'b1, -1);
            wait_end(i % 2 == 1);
        end

        begin_draw(50, 60, 10, 8, 1'b1, -1);
        while (edge_n < m_s + 10) begin @(posedge clk); #2; end
        rst_n    = 1'b0;
        m_act    = 1'b0;
        prev_cnt = 0;
        prev_to  = 1'b0;
        @(negedge clk);
        chk("t5_plot", 32'(vga_plot), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_src_reset_n", 32'(src_reset_n), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("t5_no_done", 32'(done_cnt), 32'd0);

        begin_draw(12, 34, 3, 3, 1'b1, -2);
        wait_end(1'b0);
        chk("t5_recover_count", 32'(plot_count), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout edge=%0d", edge_n);
        $fatal(1);
    end

endmodule

`default_nettype wire
